screen_pixel_writer: RTL and testbench
======================================

// Module: screen_pixel_writer
// PURPOSE
//  Writer end of the screen-RAM path. The VGA side reads the screen area through addr_screen/rdata_screen.
//  This block takes pixel/word commands over a valid/ready handshake and updates the same screen area.
//  It drives the RAM CPU port (addr/we/wdata/rdata) with read-modify-write for single bits.
//  One command is in flight at a time; FILL walks the whole screen area, one word per cycle.
// PARAMETERS
//  RAM_WIDTH               16   bits per RAM word
//  RAM_REGISTER_COUNT      256  RAM depth; ram_addr width = $clog2(RAM_REGISTER_COUNT)
//  RAM_SCREEN_OFFSET       0    word address of screen word 0
//  BITS_PER_MEMORY_PIXEL_X 4    log2 of screen pixels per memory pixel, X
//  SCREEN_ROWS             15   memory-pixel rows (480 >> BITS_PER_MEMORY_PIXEL_Y)
//  Derived: WORDS_PER_LINE = 512 >> ($clog2(RAM_WIDTH)+BITS_PER_MEMORY_PIXEL_X) = 2
//  Derived: SCREEN_WORDS = SCREEN_ROWS*WORDS_PER_LINE = 30
// PORTS
//  CLK_50     in   1           system clock; all logic on rising edge
//  resetN     in   1           synchronous active-low reset
//  cmd_valid  in   1           command present
//  cmd_ready  out  1           block can accept; high only in IDLE
//  cmd_op     in   3           0 NOP, 1 SET, 2 CLR, 3 TOG, 4 WRITE_WORD, 5 FILL, 6/7 illegal
//  cmd_x      in   5           memory-pixel column, 0..31
//  cmd_y      in   4           memory-pixel row, 0..SCREEN_ROWS-1
//  cmd_data   in   RAM_WIDTH   word for WRITE_WORD/FILL
//  busy       out  1           ~cmd_ready
//  done       out  1           one-cycle pulse when a command completes
//  err        out  1           one-cycle pulse on an illegal op or cmd_y >= SCREEN_ROWS; no RAM write occurs
//  ram_addr   out  $clog2(RAM_REGISTER_COUNT)  RAM CPU-port address
//  ram_we     out  1           RAM write enable
//  ram_wdata  out  RAM_WIDTH   RAM write data
//  ram_rdata  in   RAM_WIDTH   RAM read data; valid 1 cycle after ram_addr (synchronous read)
// BEHAVIOUR
//  Reset (resetN=0 at an edge):
//   - state=IDLE; cmd_ready=1, busy=0, done=0, err=0, ram_we=0, ram_addr=0, ram_wdata=0.
//   - Aborts any operation; no further writes after the reset edge.
//  Accept: cmd_valid&&cmd_ready at edge T latches op/x/y/data. Inputs are ignored while busy.
//  Address: wa = RAM_SCREEN_OFFSET + cmd_y*WORDS_PER_LINE + (cmd_x >> $clog2(RAM_WIDTH)), truncated to addr width.
//  Bit: b = RAM_WIDTH-1 - (cmd_x % RAM_WIDTH); the leftmost pixel is the MSB.
//  States: IDLE, RD, WR, FILL, FIN.
//  SET/CLR/TOG (3 cycles):
//   - T+1 RD: ram_addr=wa, ram_we=0.
//   - T+2 WR: ram_we=1, ram_wdata = ram_rdata with bit b set/cleared/inverted; done=1.
//   - T+3 IDLE.
//  WRITE_WORD: T+1 WR: ram_addr=wa, ram_wdata=cmd_data, ram_we=1, done=1; T+2 IDLE. cmd_x bits below the word index are ignored.
//  FILL:
//   - T+1..T+SCREEN_WORDS: ram_we=1, ram_addr = OFFSET+0, +1, ... +SCREEN_WORDS-1, ram_wdata=cmd_data.
//   - done=1 on the last write cycle. Counter is 0..SCREEN_WORDS-1 and does not wrap.
//  NOP: T+1 FIN: done=1; back to IDLE.
//  Illegal op or y out of range: T+1 FIN with err=1 and done=0; ram_we stays 0.
//  done and err are never high together. ram_we is high only in WR/FILL.
//  cmd_ready returns high the cycle after done/err, so back-to-back commands are accepted every 2nd cycle at best.
//  Width rules: ram_wdata is exactly RAM_WIDTH bits; the address sum is computed at 32 bits, then truncated.
// TESTING
//  - RAM all 0; SET x=3,y=2 -> RD addr 4, then WR addr 4 wdata 16'h1000, done on the WR cycle, ready after.
//  - Word 4 = 16'h1000; TOG x=3,y=2 -> wdata 16'h0000; TOG again -> 16'h1000; CLR x=19,y=0 on 16'hFFFF @1 -> 16'hEFFF.
//  - FILL cmd_data=16'hA5A5 -> 30 consecutive we cycles, addr 0..29, done on addr 29, nothing written to addr 30.
//  - SET y=15 -> err pulse 1 cycle, ram_we never 1, done=0; op=6 -> same.
//  - cmd_valid held high with 2 SETs queued -> second accepted only when cmd_ready=1; no overlap of RD/WR.
//  - resetN=0 during FILL at addr 10 -> ram_we=0 from next cycle, ready=1, addr 11 never written.

Source files
------------

// File: rtl/screen_pixel_writer.sv
// rtl/screen_pixel_writer.sv - pixel/word command writer onto the screen-RAM CPU port
// Single-bit ops use read-modify-write; FILL streams one word per cycle across the screen area.
module screen_pixel_writer #(
  parameter int RAM_WIDTH               = 16,
  parameter int RAM_REGISTER_COUNT      = 256,
  parameter int RAM_SCREEN_OFFSET       = 0,
  parameter int BITS_PER_MEMORY_PIXEL_X = 4,
  parameter int SCREEN_ROWS             = 15
) (
  input  logic                                  CLK_50,
  input  logic                                  resetN,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [2:0]                            cmd_op,
  input  logic [4:0]                            cmd_x,
  input  logic [3:0]                            cmd_y,
  input  logic [RAM_WIDTH-1:0]                  cmd_data,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic [$clog2(RAM_REGISTER_COUNT)-1:0] ram_addr,
  output logic                                  ram_we,
  output logic [RAM_WIDTH-1:0]                  ram_wdata,
  input  logic [RAM_WIDTH-1:0]                  ram_rdata
);

  localparam int AW             = $clog2(RAM_REGISTER_COUNT);
  localparam int BIT_W          = $clog2(RAM_WIDTH);
  localparam int WORDS_PER_LINE = 512 >> (BIT_W + BITS_PER_MEMORY_PIXEL_X);
  localparam int SCREEN_WORDS   = SCREEN_ROWS * WORDS_PER_LINE;
  localparam int CNT_W          = (SCREEN_WORDS > 1) ? $clog2(SCREEN_WORDS) : 1;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_SET   = 3'd1;
  localparam logic [2:0] OP_CLR   = 3'd2;
  localparam logic [2:0] OP_TOG   = 3'd3;
  localparam logic [2:0] OP_WRITE = 3'd4;
  localparam logic [2:0] OP_FILL  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FILL = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [2:0]           r_op;
  logic [4:0]           r_x;
  logic [3:0]           r_y;
  logic [RAM_WIDTH-1:0] r_data;
  logic                 r_err;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_accept;
  logic                 w_bad;
  logic [AW-1:0]        w_wa;
  logic [BIT_W-1:0]     w_bit;
  logic [RAM_WIDTH-1:0] w_mask;
  logic [AW-1:0]        w_fill_addr;
  logic                 w_fill_last;

  assign w_accept = (r_state == S_IDLE) && cmd_valid;
  assign w_bad    = (cmd_op > OP_FILL) || (int'(cmd_y) >= SCREEN_ROWS);

  // Address arithmetic is done at 32 bits and only then cut to the RAM address width.
  assign w_wa        = AW'(RAM_SCREEN_OFFSET + int'(r_y) * WORDS_PER_LINE + int'(r_x >> BIT_W));
  assign w_bit       = BIT_W'(RAM_WIDTH - 1 - (int'(r_x) % RAM_WIDTH));
  assign w_mask      = {{(RAM_WIDTH-1){1'b0}}, 1'b1} << w_bit;
  assign w_fill_addr = AW'(RAM_SCREEN_OFFSET + int'(r_cnt));
  assign w_fill_last = (r_cnt == CNT_W'(SCREEN_WORDS - 1));

  always_ff @(posedge CLK_50) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_x    <= cmd_x;
        r_y    <= cmd_y;
        r_data <= cmd_data;
        r_err  <= w_bad;
        r_cnt  <= '0;
      end else if (r_state == S_FILL && !w_fill_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (w_bad || cmd_op == OP_NOP) begin
            w_next_state = S_FIN;
          end else if (cmd_op == OP_WRITE) begin
            w_next_state = S_WR;
          end else if (cmd_op == OP_FILL) begin
            w_next_state = S_FILL;
          end else begin
            w_next_state = S_RD;
          end
        end
      end
      S_RD:    w_next_state = S_WR;
      S_WR:    w_next_state = S_IDLE;
      S_FILL:  w_next_state = w_fill_last ? S_IDLE : S_FILL;
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // The WR cycle of a bit op sees the word fetched during RD on ram_rdata.
  always_comb begin
    cmd_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (r_state)
      S_IDLE: cmd_ready = 1'b1;
      S_RD:   ram_addr  = w_wa;
      S_WR: begin
        ram_addr = w_wa;
        ram_we   = 1'b1;
        done     = 1'b1;
        case (r_op)
          OP_SET:  ram_wdata = ram_rdata | w_mask;
          OP_CLR:  ram_wdata = ram_rdata & ~w_mask;
          OP_TOG:  ram_wdata = ram_rdata ^ w_mask;
          default: ram_wdata = r_data;
        endcase
      end
      S_FILL: begin
        ram_addr  = w_fill_addr;
        ram_we    = 1'b1;
        ram_wdata = r_data;
        done      = w_fill_last;
      end
      S_FIN: begin
        done = ~r_err;
        err  = r_err;
      end
      default: ;
    endcase
  end

  assign busy = ~cmd_ready;

endmodule

// File: tb/tb_screen_pixel_writer.sv
// tb/tb_screen_pixel_writer.sv - randomized self-checking bench for screen_pixel_writer
// A behavioural RAM sits on the CPU port; expected contents come from a word-level screen model.
module tb_screen_pixel_writer;

  localparam int OFF   = 0;
  localparam int WPL   = 2;
  localparam int ROWS  = 15;
  localparam int WORDS = ROWS * WPL;

  logic        CLK_50 = 1'b0;
  logic        resetN = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [4:0]  cmd_x = '0;
  logic [3:0]  cmd_y = '0;
  logic [15:0] cmd_data = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;

  always #10 CLK_50 = ~CLK_50;

  screen_pixel_writer dut (
    .CLK_50    (CLK_50),
    .resetN    (resetN),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_data  (cmd_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  logic [15:0] mem     [256] = '{default: 16'h0000};
  logic [15:0] exp_mem [256] = '{default: 16'h0000};
  logic        bd_we   = 1'b0;
  logic [7:0]  bd_addr = '0;
  logic [15:0] bd_data = '0;

  always @(posedge CLK_50) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int viol = 0;
  always @(negedge CLK_50) begin
    if (resetN) begin
      if (done && err) viol++;
      if (ram_we && cmd_ready) viol++;
      if (busy !== ~cmd_ready) viol++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic int wa_of(input int x, input int y);
    return (OFF + y * WPL + x / 16) % 256;
  endfunction

  function automatic logic [15:0] apply_bit(input logic [2:0] op, input logic [15:0] old, input int x);
    logic [15:0] m;
    m = 16'h8000 >> (x % 16);
    case (op)
      3'd1:    return old | m;
      3'd2:    return old & ~m;
      default: return old ^ m;
    endcase
  endfunction

  function automatic int mem_mismatches();
    int c = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) c++;
    return c;
  endfunction

  task automatic poke(input int a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = 8'(a); bd_data = d;
    @(negedge CLK_50);
    bd_we = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_err"},   err, 0);
    check({tag, "_we"},    ram_we, 0);
    check({tag, "_addr"},  ram_addr, 0);
    check({tag, "_wdata"}, ram_wdata, 0);
  endtask

  // Issues one command (entered and left on a negedge) and checks its whole transaction.
  task automatic run_cmd(input logic [2:0] op, input logic [4:0] x, input logic [3:0] y,
                         input logic [15:0] d, input string tag);
    logic [23:0] exp_w[$];
    logic [23:0] got_w[$];
    int  lat, wa, k, n, seq_bad;
    bit  bad, seen_done, seen_err, rd_ok;
    bad = (op > 3'd5) || (int'(y) >= ROWS);
    wa  = wa_of(x, y);
    lat = 1;
    if (!bad) begin
      case (op)
        3'd1, 3'd2, 3'd3: begin
          lat = 2;
          exp_w.push_back({wa[7:0], apply_bit(op, exp_mem[wa], x)});
        end
        3'd4: exp_w.push_back({wa[7:0], d});
        3'd5: begin
          lat = WORDS;
          for (int i = 0; i < WORDS; i++) exp_w.push_back({8'(OFF + i), d});
        end
        default: ;
      endcase
    end
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge CLK_50);
      n++;
    end
    check({tag, "_ready_in"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_data = d;
    @(negedge CLK_50);
    cmd_op = 3'($urandom); cmd_x = 5'($urandom); cmd_y = 4'($urandom); cmd_data = 16'($urandom);
    k = 0; seen_done = 0; seen_err = 0; rd_ok = 1;
    while (k < 40) begin
      k++;
      if (k == 1 && lat == 2) rd_ok = (ram_addr == wa[7:0]) && !ram_we;
      if (ram_we) got_w.push_back({ram_addr, ram_wdata});
      if (done || err) begin
        seen_done = done;
        seen_err  = err;
        break;
      end
      @(negedge CLK_50);
    end
    cmd_valid = 1'b0;
    check({tag, "_latency"}, k, lat);
    check({tag, "_done"}, seen_done, !bad);
    check({tag, "_err"}, seen_err, bad);
    check({tag, "_rd_cycle"}, rd_ok, 1);
    check({tag, "_nwrites"}, got_w.size(), exp_w.size());
    seq_bad = 0;
    for (int i = 0; i < exp_w.size(); i++)
      if (i >= got_w.size() || got_w[i] !== exp_w[i]) seq_bad++;
    check({tag, "_write_seq"}, seq_bad, 0);
    foreach (exp_w[i]) exp_mem[exp_w[i][23:16]] = exp_w[i][15:0];
    @(negedge CLK_50);
    check({tag, "_ready_after"}, cmd_ready, 1);
    check({tag, "_mem"}, mem_mismatches(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, got_done, got_we, k;
    logic [2:0] rop;

    repeat (3) @(negedge CLK_50);
    check_idle_outputs("reset");
    resetN = 1'b1;
    @(negedge CLK_50);

    run_cmd(3'd1, 5'd3, 4'd2, 16'h0, "set_3_2");
    check("set_word4", mem[4], 16'h1000);
    run_cmd(3'd3, 5'd3, 4'd2, 16'h0, "tog1");
    check("tog1_word4", mem[4], 16'h0000);
    run_cmd(3'd3, 5'd3, 4'd2, 16'h0, "tog2");
    check("tog2_word4", mem[4], 16'h1000);
    poke(1, 16'hFFFF);
    run_cmd(3'd2, 5'd19, 4'd0, 16'h0, "clr_19_0");
    check("clr_word1", mem[1], 16'hEFFF);

    poke(30, 16'h1234);
    run_cmd(3'd5, 5'd0, 4'd0, 16'hA5A5, "fill");
    check("fill_last", mem[29], 16'hA5A5);
    check("fill_beyond", mem[30], 16'h1234);

    run_cmd(3'd1, 5'd3, 4'd15, 16'h0, "set_y15");
    run_cmd(3'd6, 5'd3, 4'd2, 16'h0, "op6");
    run_cmd(3'd7, 5'd0, 4'd0, 16'h0, "op7");
    run_cmd(3'd0, 5'd9, 4'd4, 16'h0, "nop");
    run_cmd(3'd4, 5'd17, 4'd14, 16'hBEEF, "write_word");
    check("write_word29", mem[29], 16'hBEEF);

    // Two SETs with cmd_valid held high throughout.
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_x = 5'd5; cmd_y = 4'd7; cmd_data = '0;
    acc = 1; got_done = 0; got_we = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK_50);
      if (done) got_done |= (1 << c);
      if (ram_we) got_we |= (1 << c);
      if (c == 1) check("b2b_rd_a", ram_addr, 8'd14);
      if (c == 4) check("b2b_rd_b", ram_addr, 8'd7);
      if (acc == 2) cmd_valid = 1'b0;
      if (cmd_valid && cmd_ready) acc++;
      if (c == 1) begin
        cmd_x = 5'd20;
        cmd_y = 4'd3;
      end
    end
    check("b2b_accepts", acc, 2);
    check("b2b_done_cycles", got_done, 32'h24);
    check("b2b_we_cycles", got_we, 32'h24);
    exp_mem[14] = apply_bit(3'd1, exp_mem[14], 5);
    exp_mem[7]  = apply_bit(3'd1, exp_mem[7], 20);
    check("b2b_mem", mem_mismatches(), 0);

    // Reset in the middle of a FILL.
    poke(11, 16'h0F0F);
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_x = '0; cmd_y = '0; cmd_data = 16'h3C3C;
    @(negedge CLK_50);
    cmd_valid = 1'b0;
    k = 0;
    while (!(ram_we && ram_addr == 8'd10) && k < 40) begin
      @(negedge CLK_50);
      k++;
    end
    check("rst_reach_addr10", (ram_we && ram_addr == 8'd10), 1);
    resetN = 1'b0;
    @(negedge CLK_50);
    check_idle_outputs("rst_fill");
    repeat (2) @(negedge CLK_50);
    resetN = 1'b1;
    @(negedge CLK_50);
    for (int i = 0; i <= 10; i++) exp_mem[OFF + i] = 16'h3C3C;
    check("rst_addr10", mem[10], 16'h3C3C);
    check("rst_addr11", mem[11], 16'h0F0F);
    check("rst_mem", mem_mismatches(), 0);

    for (int t = 0; t < 60; t++) begin
      rop = 3'($urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) @(negedge CLK_50);
      run_cmd(rop, 5'($urandom), 4'($urandom_range(0, 15)), 16'($urandom), $sformatf("rnd%0d", t));
    end

    check("invariants", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
